// File: rtl/pdp8_pkg.sv
// Shared PDP-8 definitions: memory-reference opcodes, execute sequencer states
// and the auto-index address window.
package pdp8_pkg;

    localparam int PDP8_ADDR_WIDTH = 12;
    localparam int PDP8_DATA_WIDTH = 12;

    localparam logic [11:0] AUTOINC_LO_DFLT = 12'o0010;
    localparam logic [11:0] AUTOINC_HI_DFLT = 12'o0017;

    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_TAD = 3'd1,
        OP_ISZ = 3'd2,
        OP_DCA = 3'd3,
        OP_JMS = 3'd4,
        OP_JMP = 3'd5
    } mem_op_e;

    typedef enum logic [2:0] {
        IDLE,
        IND_RD,
        IND_WAIT,
        AUTO_WR,
        OP_RD,
        OP_WAIT,
        OP_WR,
        DONE
    } exec_seq_state_e;

    // First state once the effective address is final.
    function automatic exec_seq_state_e dispatch_state(input logic [2:0] op);
        exec_seq_state_e nxt;
        case (op)
            OP_AND, OP_TAD, OP_ISZ: nxt = OP_RD;
            OP_DCA, OP_JMS:         nxt = OP_WR;
            default:                nxt = DONE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/exec_mem_sequencer.sv
// Execute-stage memory sequencer: resolves indirect/auto-index addressing and
// runs the operand read/write traffic for one memory-reference instruction.
module exec_mem_sequencer
    import pdp8_pkg::*;
#(
    parameter int                    ADDR_WIDTH = PDP8_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = PDP8_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] AUTOINC_LO = ADDR_WIDTH'(AUTOINC_LO_DFLT),
    parameter logic [ADDR_WIDTH-1:0] AUTOINC_HI = ADDR_WIDTH'(AUTOINC_HI_DFLT)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [2:0]            opcode,
    input  logic                  indirect,
    input  logic [ADDR_WIDTH-1:0] ea_in,
    input  logic [DATA_WIDTH-1:0] ac_in,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    output logic                  exec_rd_req,
    output logic [ADDR_WIDTH-1:0] exec_rd_addr,
    input  logic [DATA_WIDTH-1:0] exec_rd_data,
    output logic                  exec_wr_req,
    output logic [ADDR_WIDTH-1:0] exec_wr_addr,
    output logic [DATA_WIDTH-1:0] exec_wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] operand,
    output logic                  skip,
    output logic                  pc_load,
    output logic [ADDR_WIDTH-1:0] pc_target,
    output logic                  illegal
);

    exec_seq_state_e state_q, state_d;

    logic [2:0]            opcode_q, opcode_d;
    logic [ADDR_WIDTH-1:0] ea_q, ea_d;
    logic [DATA_WIDTH-1:0] ac_q, ac_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] operand_q, operand_d;
    logic                  skip_q, skip_d;
    logic [ADDR_WIDTH-1:0] pc_target_q, pc_target_d;

    logic                  rd_req_q, rd_req_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  wr_req_q, wr_req_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pc_load_q, pc_load_d;
    logic                  illegal_q, illegal_d;

    logic [DATA_WIDTH-1:0] inc_in;
    logic [DATA_WIDTH-1:0] inc_out;
    logic                  is_auto;

    // One incrementer: auto-index pointer and ISZ operand come off the read
    // bus, the JMS return target comes from the resolved EA during OP_WR.
    assign inc_in  = (state_q == OP_WR) ? DATA_WIDTH'(ea_q) : exec_rd_data;
    assign inc_out = inc_in + DATA_WIDTH'(1);
    assign is_auto = (ea_q >= AUTOINC_LO) && (ea_q <= AUTOINC_HI);

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        ea_d        = ea_q;
        ac_d        = ac_q;
        pc_d        = pc_q;
        ptr_d       = ptr_q;
        operand_d   = operand_q;
        skip_d      = skip_q;
        pc_target_d = pc_target_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    opcode_d = opcode;
                    ea_d     = ea_in;
                    ac_d     = ac_in;
                    pc_d     = pc_in;
                    skip_d   = 1'b0;
                    // Illegal opcodes never touch memory, even with the I bit set.
                    if (opcode > 3'd5) begin
                        state_d = DONE;
                    end else if (indirect) begin
                        state_d = IND_RD;
                    end else begin
                        state_d = dispatch_state(opcode);
                    end
                end
            end
            IND_RD: state_d = IND_WAIT;
            IND_WAIT: begin
                if (is_auto) begin
                    ptr_d   = inc_out;
                    state_d = AUTO_WR;
                end else begin
                    ea_d    = ADDR_WIDTH'(exec_rd_data);
                    state_d = dispatch_state(opcode_q);
                end
            end
            AUTO_WR: begin
                ea_d    = ADDR_WIDTH'(ptr_q);
                state_d = dispatch_state(opcode_q);
            end
            OP_RD: state_d = OP_WAIT;
            OP_WAIT: begin
                operand_d = exec_rd_data;
                if (opcode_q == OP_ISZ) begin
                    skip_d  = (inc_out == '0);
                    state_d = OP_WR;
                end else begin
                    state_d = DONE;
                end
            end
            OP_WR: begin
                if (opcode_q == OP_JMS) begin
                    pc_target_d = ADDR_WIDTH'(inc_out);
                end
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        rd_req_d  = 1'b0;
        rd_addr_d = '0;
        wr_req_d  = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        done_d    = 1'b0;
        pc_load_d = 1'b0;
        illegal_d = 1'b0;
        busy_d    = (state_d != IDLE) && (state_d != DONE);

        case (state_d)
            IND_RD, OP_RD: begin
                rd_req_d  = 1'b1;
                rd_addr_d = ea_d;
            end
            AUTO_WR: begin
                wr_req_d  = 1'b1;
                wr_addr_d = ea_d;
                wr_data_d = ptr_d;
            end
            OP_WR: begin
                wr_req_d  = 1'b1;
                wr_addr_d = ea_d;
                if (opcode_d == OP_ISZ) begin
                    wr_data_d = inc_out;
                end else if (opcode_d == OP_DCA) begin
                    wr_data_d = ac_d;
                end else begin
                    wr_data_d = DATA_WIDTH'(pc_d);
                end
            end
            DONE: begin
                done_d    = 1'b1;
                pc_load_d = (opcode_d == OP_JMP) || (opcode_d == OP_JMS);
                illegal_d = (opcode_d > 3'd5);
                if (opcode_d == OP_JMP) begin
                    pc_target_d = ea_d;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            opcode_q    <= '0;
            ea_q        <= '0;
            ac_q        <= '0;
            pc_q        <= '0;
            ptr_q       <= '0;
            operand_q   <= '0;
            skip_q      <= 1'b0;
            pc_target_q <= '0;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= '0;
            wr_req_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pc_load_q   <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            ea_q        <= ea_d;
            ac_q        <= ac_d;
            pc_q        <= pc_d;
            ptr_q       <= ptr_d;
            operand_q   <= operand_d;
            skip_q      <= skip_d;
            pc_target_q <= pc_target_d;
            rd_req_q    <= rd_req_d;
            rd_addr_q   <= rd_addr_d;
            wr_req_q    <= wr_req_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pc_load_q   <= pc_load_d;
            illegal_q   <= illegal_d;
        end
    end

    assign exec_rd_req  = rd_req_q;
    assign exec_rd_addr = rd_addr_q;
    assign exec_wr_req  = wr_req_q;
    assign exec_wr_addr = wr_addr_q;
    assign exec_wr_data = wr_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign operand      = operand_q;
    assign skip         = skip_q;
    assign pc_load      = pc_load_q;
    assign pc_target    = pc_target_q;
    assign illegal      = illegal_q;

endmodule

// File: tb/tb_exec_mem_sequencer.sv
// Scoreboard bench for exec_mem_sequencer: a memory model answers the exec port,
// directed instructions push expected events, a monitor checks them in order.
module tb_exec_mem_sequencer;

    localparam int K_RD   = 0;
    localparam int K_WR   = 1;
    localparam int K_DONE = 2;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        start    = 1'b0;
    logic [2:0]  opcode   = '0;
    logic        indirect = 1'b0;
    logic [11:0] ea_in    = '0;
    logic [11:0] ac_in    = '0;
    logic [11:0] pc_in    = '0;
    logic        exec_rd_req;
    logic [11:0] exec_rd_addr;
    logic [11:0] exec_rd_data;
    logic        exec_wr_req;
    logic [11:0] exec_wr_addr;
    logic [11:0] exec_wr_data;
    logic        busy;
    logic        done;
    logic [11:0] operand;
    logic        skip;
    logic        pc_load;
    logic [11:0] pc_target;
    logic        illegal;

    exec_mem_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .opcode       (opcode),
        .indirect     (indirect),
        .ea_in        (ea_in),
        .ac_in        (ac_in),
        .pc_in        (pc_in),
        .exec_rd_req  (exec_rd_req),
        .exec_rd_addr (exec_rd_addr),
        .exec_rd_data (exec_rd_data),
        .exec_wr_req  (exec_wr_req),
        .exec_wr_addr (exec_wr_addr),
        .exec_wr_data (exec_wr_data),
        .busy         (busy),
        .done         (done),
        .operand      (operand),
        .skip         (skip),
        .pc_load      (pc_load),
        .pc_target    (pc_target),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data appears the cycle after the request.
    logic [11:0] mem [0:4095];
    logic [11:0] rdDataQ = '0;
    logic        pokeEn = 1'b0;
    logic [11:0] pokeAddr = '0;
    logic [11:0] pokeData = '0;

    always @(posedge clk) begin
        if (exec_rd_req) rdDataQ <= mem[exec_rd_addr];
        if (exec_wr_req) mem[exec_wr_addr] <= exec_wr_data;
        else if (pokeEn) mem[pokeAddr] <= pokeData;
    end
    assign exec_rd_data = rdDataQ;

    typedef struct {
        string       tag;
        int          kind;
        int          cyc;
        logic [11:0] addr;
        logic [11:0] data;
        bit          chkOp;
        logic        skip;
        logic        pcLoad;
        logic [11:0] target;
        logic        illegal;
    } exp_t;

    exp_t  expQ[$];
    int    nCompared = 0;
    int    nFail     = 0;
    int    t0        = 0;
    string curTag    = "none";

    // Monitor: every request or done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        int   kind;
        bit   ok;
        if (reset_n) begin
            if (exec_rd_req && exec_wr_req) begin
                nCompared++;
                nFail++;
                $display("[TB] FAIL rd_wr_exclusive cyc=%0d: got both requests, required at most one", cyc);
            end
            if (exec_rd_req || exec_wr_req || done) begin
                nCompared++;
                kind = done ? K_DONE : (exec_wr_req ? K_WR : K_RD);
                if (expQ.size() == 0) begin
                    nFail++;
                    $display("[TB] FAIL unexpected_event cyc=%0d: got kind=%0d rd=%o wr=%o/%o, required no event",
                             cyc, kind, exec_rd_addr, exec_wr_addr, exec_wr_data);
                end else begin
                    e  = expQ.pop_front();
                    ok = (kind == e.kind) && (cyc == e.cyc);
                    case (kind)
                        K_RD: if (exec_rd_addr != e.addr || !busy) ok = 0;
                        K_WR: if (exec_wr_addr != e.addr || exec_wr_data != e.data || !busy) ok = 0;
                        default: begin
                            if (busy || skip != e.skip || pc_load != e.pcLoad || illegal != e.illegal) ok = 0;
                            if (e.chkOp && operand != e.data) ok = 0;
                            if (e.pcLoad && pc_target != e.target) ok = 0;
                        end
                    endcase
                    if (!ok) begin
                        nFail++;
                        $display("[TB] FAIL %s: got kind=%0d cyc=%0d rdA=%o wrA=%o wrD=%o busy=%b op=%o skip=%b pcl=%b tgt=%o ill=%b; required kind=%0d cyc=%0d addr=%o data=%o skip=%b pcl=%b tgt=%o ill=%b",
                                 e.tag, kind, cyc, exec_rd_addr, exec_wr_addr, exec_wr_data, busy, operand, skip,
                                 pc_load, pc_target, illegal, e.kind, e.cyc, e.addr, e.data, e.skip, e.pcLoad,
                                 e.target, e.illegal);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] req);
        nCompared++;
        if (act !== req) begin
            nFail++;
            $display("[TB] FAIL %s: got %o, required %o", name, act, req);
        end
    endtask

    task automatic memPoke(input logic [11:0] a, input logic [11:0] d);
        @(posedge clk); #1;
        pokeEn = 1'b1; pokeAddr = a; pokeData = d;
        @(posedge clk); #1;
        pokeEn = 1'b0;
    endtask

    task automatic applyStimulus(input string tag, input logic [2:0] op, input logic ind,
                                 input logic [11:0] ea, input logic [11:0] ac, input logic [11:0] pc);
        @(posedge clk); #1;
        curTag = tag;
        opcode = op; indirect = ind; ea_in = ea; ac_in = ac; pc_in = pc;
        start = 1'b1;
        t0 = cyc;
    endtask

    task automatic finishStart();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic expectRd(input int off, input logic [11:0] a);
        exp_t e;
        e = '{tag: curTag, kind: K_RD, cyc: t0 + off, addr: a, data: '0, chkOp: 0,
              skip: 0, pcLoad: 0, target: '0, illegal: 0};
        expQ.push_back(e);
    endtask

    task automatic expectWr(input int off, input logic [11:0] a, input logic [11:0] d);
        exp_t e;
        e = '{tag: curTag, kind: K_WR, cyc: t0 + off, addr: a, data: d, chkOp: 0,
              skip: 0, pcLoad: 0, target: '0, illegal: 0};
        expQ.push_back(e);
    endtask

    task automatic expectDone(input int off, input bit chkOp, input logic [11:0] op, input logic sk,
                              input logic pcl, input logic [11:0] tgt, input logic ill);
        exp_t e;
        e = '{tag: curTag, kind: K_DONE, cyc: t0 + off, addr: '0, data: op, chkOp: chkOp,
              skip: sk, pcLoad: pcl, target: tgt, illegal: ill};
        expQ.push_back(e);
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 60 && expQ.size() != 0; i++) @(posedge clk);
        if (expQ.size() != 0) begin
            nCompared++;
            nFail++;
            $display("[TB] FAIL %s_timeout: got %0d events outstanding, required 0", curTag, expQ.size());
            expQ.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_rd_req", {11'b0, exec_rd_req}, 12'o0);
        checkOutput("rst_wr_req", {11'b0, exec_wr_req}, 12'o0);
        checkOutput("rst_busy",   {11'b0, busy},        12'o0);
        checkOutput("rst_done",   {11'b0, done},        12'o0);
        checkOutput("rst_operand", operand,             12'o0);
        checkOutput("rst_pc_target", pc_target,         12'o0);
        reset_n = 1'b1;

        memPoke(12'o0200, 12'o1234);
        memPoke(12'o0012, 12'o3777);
        memPoke(12'o4000, 12'o0055);
        memPoke(12'o0300, 12'o7777);
        memPoke(12'o0400, 12'o2000);
        memPoke(12'o0017, 12'o7777);
        memPoke(12'o0010, 12'o0100);
        memPoke(12'o0020, 12'o0500);
        memPoke(12'o0500, 12'o1111);

        applyStimulus("tad_direct", 3'd1, 1'b0, 12'o0200, 12'o0, 12'o0);
        expectRd(1, 12'o0200);
        expectDone(3, 1, 12'o1234, 0, 0, 12'o0, 0);
        finishStart();
        waitDrain();

        applyStimulus("and_autoidx", 3'd0, 1'b1, 12'o0012, 12'o0, 12'o0);
        expectRd(1, 12'o0012);
        expectWr(3, 12'o0012, 12'o4000);
        expectRd(4, 12'o4000);
        expectDone(6, 1, 12'o0055, 0, 0, 12'o0, 0);
        finishStart();
        waitDrain();
        checkOutput("and_autoidx_mem", mem[12'o0012], 12'o4000);

        applyStimulus("isz_wrap", 3'd2, 1'b0, 12'o0300, 12'o0, 12'o0);
        expectRd(1, 12'o0300);
        expectWr(3, 12'o0300, 12'o0000);
        expectDone(4, 1, 12'o7777, 1, 0, 12'o0, 0);
        finishStart();
        waitDrain();

        memPoke(12'o0300, 12'o0005);
        applyStimulus("isz_noskip", 3'd2, 1'b0, 12'o0300, 12'o0, 12'o0);
        expectRd(1, 12'o0300);
        expectWr(3, 12'o0300, 12'o0006);
        expectDone(4, 1, 12'o0005, 0, 0, 12'o0, 0);
        finishStart();
        waitDrain();

        applyStimulus("jms_indirect", 3'd4, 1'b1, 12'o0400, 12'o0, 12'o0123);
        expectRd(1, 12'o0400);
        expectWr(3, 12'o2000, 12'o0123);
        expectDone(4, 0, 12'o0, 0, 1, 12'o2001, 0);
        finishStart();
        waitDrain();
        checkOutput("jms_indirect_mem", mem[12'o2000], 12'o0123);

        // Extra starts while busy and in the DONE cycle must be ignored.
        applyStimulus("dca_busy_start", 3'd3, 1'b0, 12'o0777, 12'o4321, 12'o0);
        expectWr(1, 12'o0777, 12'o4321);
        expectDone(2, 0, 12'o0, 0, 0, 12'o0, 0);
        finishStart();
        opcode = 3'd5; ea_in = 12'o1111; start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        waitDrain();
        checkOutput("dca_mem", mem[12'o0777], 12'o4321);

        applyStimulus("jmp_direct", 3'd5, 1'b0, 12'o1234, 12'o0, 12'o0);
        expectDone(1, 0, 12'o0, 0, 1, 12'o1234, 0);
        finishStart();
        waitDrain();

        applyStimulus("jmp_auto_hi_wrap", 3'd5, 1'b1, 12'o0017, 12'o0, 12'o0);
        expectRd(1, 12'o0017);
        expectWr(3, 12'o0017, 12'o0000);
        expectDone(4, 0, 12'o0, 0, 1, 12'o0000, 0);
        finishStart();
        waitDrain();

        applyStimulus("jmp_auto_lo", 3'd5, 1'b1, 12'o0010, 12'o0, 12'o0);
        expectRd(1, 12'o0010);
        expectWr(3, 12'o0010, 12'o0101);
        expectDone(4, 0, 12'o0, 0, 1, 12'o0101, 0);
        finishStart();
        waitDrain();

        applyStimulus("and_ind_020", 3'd0, 1'b1, 12'o0020, 12'o0, 12'o0);
        expectRd(1, 12'o0020);
        expectRd(3, 12'o0500);
        expectDone(5, 1, 12'o1111, 0, 0, 12'o0, 0);
        finishStart();
        waitDrain();

        applyStimulus("jms_wrap", 3'd4, 1'b0, 12'o7777, 12'o0, 12'o0050);
        expectWr(1, 12'o7777, 12'o0050);
        expectDone(2, 0, 12'o0, 0, 1, 12'o0000, 0);
        finishStart();
        waitDrain();

        // Reset while ISZ waits for its operand: the write must never happen.
        memPoke(12'o0300, 12'o1234);
        applyStimulus("isz_reset", 3'd2, 1'b0, 12'o0300, 12'o0, 12'o0);
        expectRd(1, 12'o0300);
        finishStart();
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        checkOutput("isz_reset_busy",   {11'b0, busy},        12'o0);
        checkOutput("isz_reset_rd_req", {11'b0, exec_rd_req}, 12'o0);
        checkOutput("isz_reset_wr_req", {11'b0, exec_wr_req}, 12'o0);
        checkOutput("isz_reset_done",   {11'b0, done},        12'o0);
        checkOutput("isz_reset_operand", operand,             12'o0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        checkOutput("isz_reset_mem", mem[12'o0300], 12'o1234);
        checkOutput("isz_reset_queue", 12'(expQ.size()), 12'o0);
        expQ.delete();

        applyStimulus("illegal_op7", 3'd7, 1'b1, 12'o0100, 12'o0, 12'o0);
        expectDone(1, 1, 12'o0, 0, 0, 12'o0, 1);
        finishStart();
        waitDrain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
        $finish;
    end

endmodule
